// File: rtl/alaw_serial_rx.sv
// Serial G.711 A-law receiver: frames 8-bit codes on fsync, expands them to
// 13-bit sign-magnitude samples and queues them behind a valid/ready port.
// Optional line even-bit inversion: define ALAW_RX_XOR_EN.
module alaw_serial_rx #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        bit_en,
    input  logic        sdata,
    input  logic        fsync,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [12:0] out_lin,
    output logic [7:0]  out_code,
    output logic        overflow,
    output logic        frame_err,
    input  logic        err_clr
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

`ifdef ALAW_RX_XOR_EN
    localparam logic [7:0] XOR_MASK = 8'h55;
`else
    localparam logic [7:0] XOR_MASK = 8'h00;
`endif

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t     state_reg, state_next;
    logic [3:0] count_reg, count_next;
    logic [6:0] shreg_reg, shreg_next;
    logic       push;
    logic       frame_err_set;
    logic [7:0] rx_byte;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            count_reg <= 4'd0;
            shreg_reg <= 7'd0;
        end else begin
            state_reg <= state_next;
            count_reg <= count_next;
            shreg_reg <= shreg_next;
        end
    end

    // An fsync strobe always restarts the byte, whether idle or mid-byte.
    always_comb begin
        state_next = state_reg;
        count_next = count_reg;
        shreg_next = shreg_reg;
        if (bit_en) begin
            case (state_reg)
                IDLE: begin
                    if (fsync) begin
                        shreg_next = {6'd0, sdata};
                        count_next = 4'd1;
                        state_next = SHIFT;
                    end
                end
                SHIFT: begin
                    if (fsync) begin
                        shreg_next = {6'd0, sdata};
                        count_next = 4'd1;
                    end else if (count_reg == 4'd7) begin
                        shreg_next = {shreg_reg[5:0], sdata};
                        count_next = 4'd0;
                        state_next = IDLE;
                    end else begin
                        shreg_next = {shreg_reg[5:0], sdata};
                        count_next = count_reg + 4'd1;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_comb begin
        push          = 1'b0;
        frame_err_set = 1'b0;
        if (bit_en && state_reg == SHIFT) begin
            if (fsync)
                frame_err_set = 1'b1;
            else if (count_reg == 4'd7)
                push = 1'b1;
        end
        rx_byte = {shreg_reg, sdata} ^ XOR_MASK;
    end

    // Expansion: code s eee mmmm -> sign ~s, magnitude {1,m,1} << (e-1), or {m,1} for e=0.
    logic [2:0]  dec_exp;
    logic [3:0]  dec_man;
    logic [11:0] dec_base;
    logic [11:0] dec_mag;
    logic [12:0] dec_lin;

    always_comb begin
        dec_exp  = rx_byte[6:4];
        dec_man  = rx_byte[3:0];
        dec_base = {6'd0, 1'b1, dec_man, 1'b1};
        if (dec_exp == 3'd0)
            dec_mag = {7'd0, dec_man, 1'b1};
        else
            dec_mag = dec_base << (dec_exp - 3'd1);
        dec_lin = {~rx_byte[7], dec_mag};
    end

    logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [CNT_W-1:0] fill_reg;
    logic [12:0]      lin_mem  [FIFO_DEPTH];
    logic [7:0]       code_mem [FIFO_DEPTH];
    logic             full;
    logic             pop;
    logic             push_ok;

    assign full    = (fill_reg == FULL_CNT);
    assign pop     = out_valid && out_ready;
    assign push_ok = push && (!full || pop);

    always_ff @(posedge clk) begin
        if (push_ok) begin
            lin_mem[wr_ptr_reg]  <= dec_lin;
            code_mem[wr_ptr_reg] <= rx_byte;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            fill_reg   <= '0;
        end else begin
            if (push_ok)
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            if (pop)
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            case ({push_ok, pop})
                2'b10:   fill_reg <= fill_reg + CNT_W'(1);
                2'b01:   fill_reg <= fill_reg - CNT_W'(1);
                default: fill_reg <= fill_reg;
            endcase
        end
    end

    // Head is gated so the outputs read zero (not stale storage) while empty.
    assign out_valid = (fill_reg != '0);
    assign out_lin   = out_valid ? lin_mem[rd_ptr_reg]  : 13'd0;
    assign out_code  = out_valid ? code_mem[rd_ptr_reg] : 8'd0;

    always_ff @(posedge clk) begin
        if (rst) begin
            overflow  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            if (push && full && !pop)
                overflow <= 1'b1;
            else if (err_clr)
                overflow <= 1'b0;
            if (frame_err_set)
                frame_err <= 1'b1;
            else if (err_clr)
                frame_err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alaw_serial_rx.sv
// Directed bench for alaw_serial_rx: a scoreboard queue of expected
// {code, linear} pairs is drained by a monitor on every output handshake.
module tb_alaw_serial_rx;

    logic        clk = 1'b0;
    logic        rst;
    logic        bit_en;
    logic        sdata;
    logic        fsync;
    logic        out_valid;
    logic        out_ready;
    logic [12:0] out_lin;
    logic [7:0]  out_code;
    logic        overflow;
    logic        frame_err;
    logic        err_clr;

    int checks = 0;
    int errors = 0;
    logic [20:0] sb_q[$];

`ifdef ALAW_RX_XOR_EN
    localparam logic [7:0] LINE_XOR = 8'h55;
`else
    localparam logic [7:0] LINE_XOR = 8'h00;
`endif

    alaw_serial_rx #(.FIFO_DEPTH(4)) dut (
        .clk(clk), .rst(rst), .bit_en(bit_en), .sdata(sdata), .fsync(fsync),
        .out_valid(out_valid), .out_ready(out_ready), .out_lin(out_lin),
        .out_code(out_code), .overflow(overflow), .frame_err(frame_err),
        .err_clr(err_clr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Sends code (line byte = code ^ LINE_XOR) with a strobe every gap cycles.
    task automatic send_byte(input logic [7:0] code, input logic [12:0] lin,
                             input int gap, input bit keep, input bit lat);
        logic [7:0] line;
        line = code ^ LINE_XOR;
        if (keep)
            sb_q.push_back({code, lin});
        for (int i = 7; i >= 0; i--) begin
            bit_en = 1'b1;
            sdata  = line[i];
            fsync  = (i == 7);
            if (i == 0 && lat)
                chk("no_fallthrough", 32'(out_valid), 32'd0);
            tick();
            bit_en = 1'b0;
            fsync  = 1'b0;
            if (i == 0 && lat)
                chk("valid_latency", 32'(out_valid), 32'd1);
            repeat (gap - 1) tick();
        end
    endtask

    task automatic send_partial(input int nbits);
        for (int i = 0; i < nbits; i++) begin
            bit_en = 1'b1;
            sdata  = 1'b1;
            fsync  = (i == 0);
            tick();
            bit_en = 1'b0;
            fsync  = 1'b0;
            tick();
        end
    endtask

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                chk("sb_has_entry", 32'd0, 32'd1);
            end else begin
                logic [20:0] e;
                e = sb_q.pop_front();
                chk("out_code", 32'(out_code), 32'(e[20:13]));
                chk("out_lin", 32'(out_lin), 32'(e[12:0]));
                $display("rx code=%h lin=%h (exp code=%h lin=%h)", out_code, out_lin, e[20:13], e[12:0]);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; bit_en = 1'b0; sdata = 1'b0; fsync = 1'b0;
        out_ready = 1'b0; err_clr = 1'b0;
        tick(); tick();
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_lin", 32'(out_lin), 32'd0);
        chk("rst_code", 32'(out_code), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        chk("rst_frame_err", 32'(frame_err), 32'd0);
        rst = 1'b0;
        tick();

        // Latency and basic decode, strobe every 3rd cycle.
        out_ready = 1'b1;
        send_byte(8'h80, 13'h0001, 3, 1'b1, 1'b1);
        send_byte(8'h00, 13'h1001, 3, 1'b1, 1'b1);
        repeat (4) tick();

        // Back-to-back frames with continuous strobes.
        send_byte(8'hFF, 13'h0FC0, 1, 1'b1, 1'b0);
        send_byte(8'h7F, 13'h1FC0, 1, 1'b1, 1'b0);
        send_byte(8'h95, 13'h002B, 1, 1'b1, 1'b0);
        repeat (4) tick();
        chk("no_frame_err_b2b", 32'(frame_err), 32'd0);
        chk("sb_drained_1", 32'(sb_q.size()), 32'd0);

        // Overflow: fifth frame into a full FIFO is dropped.
        out_ready = 1'b0;
        send_byte(8'h80, 13'h0001, 1, 1'b1, 1'b0);
        send_byte(8'h00, 13'h1001, 1, 1'b1, 1'b0);
        send_byte(8'hFF, 13'h0FC0, 1, 1'b1, 1'b0);
        send_byte(8'h7F, 13'h1FC0, 1, 1'b1, 1'b0);
        send_byte(8'h95, 13'h002B, 1, 1'b0, 1'b0);
        tick();
        chk("overflow_set", 32'(overflow), 32'd1);
        chk("full_valid", 32'(out_valid), 32'd1);
        chk("head_stable_code", 32'(out_code), 32'h80);
        chk("head_stable_lin", 32'(out_lin), 32'h0001);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("overflow_clr", 32'(overflow), 32'd0);
        out_ready = 1'b1;
        repeat (6) tick();
        chk("drained_valid", 32'(out_valid), 32'd0);
        chk("sb_drained_2", 32'(sb_q.size()), 32'd0);

        // Frame error: fsync after 5 bits, then a full frame.
        send_partial(5);
        send_byte(8'h80, 13'h0001, 2, 1'b1, 1'b0);
        repeat (4) tick();
        chk("frame_err_set", 32'(frame_err), 32'd1);
        chk("one_sample_valid", 32'(out_valid), 32'd0);
        chk("sb_drained_3", 32'(sb_q.size()), 32'd0);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("frame_err_clr", 32'(frame_err), 32'd0);

        // Reset mid-byte with two samples buffered.
        out_ready = 1'b0;
        send_byte(8'hFF, 13'h0FC0, 1, 1'b0, 1'b0);
        send_byte(8'h00, 13'h1001, 1, 1'b0, 1'b0);
        send_partial(4);
        chk("pre_rst_valid", 32'(out_valid), 32'd1);
        rst = 1'b1;
        tick();
        chk("post_rst_valid", 32'(out_valid), 32'd0);
        rst = 1'b0;
        out_ready = 1'b1;
        send_byte(8'h80, 13'h0001, 1, 1'b1, 1'b1);
        repeat (4) tick();
        chk("sb_drained_4", 32'(sb_q.size()), 32'd0);

`ifdef ALAW_RX_XOR_EN
        // Line byte D5 after even-bit inversion is code 80.
        send_byte(8'h80, 13'h0001, 1, 1'b1, 1'b1);
        repeat (4) tick();
        chk("sb_drained_xor", 32'(sb_q.size()), 32'd0);
`endif

        chk("final_valid", 32'(out_valid), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
